// File: rtl/dmi_resp_target.sv
// rtl/dmi_resp_target.sv - DMI responder with local register bank and programmable response latency
// Optional feature macro: DMI_RESP_TARGET_STALL_CNT_EN (P-channel stall counter readable at address NUM_REGS)
module dmi_resp_target #(
    parameter int unsigned ADDR_WIDTH   = 7,
    parameter int unsigned NUM_REGS     = 16,
    parameter logic [31:0] ID_VALUE     = 32'h0000_0DB1,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDR_WIDTH-1:0]    q_addr_i,
    input  logic [1:0]               q_op_i,
    input  logic [31:0]              q_data_i,
    input  logic                     q_valid_i,
    output logic                     q_ready_o,
    output logic [31:0]              p_data_o,
    output logic                     p_resp_o,
    output logic                     p_valid_o,
    input  logic                     p_ready_i,
    output logic [NUM_REGS*32-1:0]   regs_o
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned LAT_W = (RESP_LATENCY > 2) ? $clog2(RESP_LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               q_ready_q;
    logic [31:0]        p_data_q;
    logic               p_resp_q;
    logic [31:0]        bank_q [NUM_REGS];

    logic               accept;
    logic [31:0]        addr_ext;
    logic               in_range;
    logic               addr_is_zero;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        exec_data;
    logic               exec_resp;
    logic               do_write;

`ifdef DMI_RESP_TARGET_STALL_CNT_EN
    logic [31:0]        stall_cnt_q;
    logic               addr_is_cnt;
    logic               cnt_clr;
    assign addr_is_cnt = (addr_ext == NUM_REGS);
`endif

    // Full-width address compare: no aliasing of out-of-range addresses
    assign accept       = q_valid_i && q_ready_q;
    assign addr_ext     = 32'(q_addr_i);
    assign in_range     = (addr_ext < NUM_REGS);
    assign addr_is_zero = (addr_ext == 32'd0);
    assign idx          = q_addr_i[IDX_W-1:0];

    // Decode the request currently on Q into response fields and side effects
    always_comb begin
        exec_data = 32'd0;
        exec_resp = 1'b0;
        do_write  = 1'b0;
`ifdef DMI_RESP_TARGET_STALL_CNT_EN
        cnt_clr   = 1'b0;
`endif
        case (q_op_i)
            2'd0: begin
            end
            2'd1: begin
                if (in_range) begin
                    exec_data = addr_is_zero ? ID_VALUE : bank_q[idx];
                end
`ifdef DMI_RESP_TARGET_STALL_CNT_EN
                else if (addr_is_cnt) begin
                    exec_data = stall_cnt_q;
                end
`endif
                else begin
                    exec_resp = 1'b1;
                end
            end
            2'd2: begin
                if (in_range && !addr_is_zero) begin
                    do_write  = 1'b1;
                    exec_data = q_data_i;
                end
`ifdef DMI_RESP_TARGET_STALL_CNT_EN
                else if (addr_is_cnt) begin
                    cnt_clr = 1'b1;
                end
`endif
                else begin
                    exec_resp = 1'b1;
                end
            end
            default: exec_resp = 1'b1;
        endcase
    end

    // Next-state logic: IDLE accepts, WAIT burns latency, RESP holds until P handshake
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (RESP_LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        lat_d   = LAT_W'(RESP_LATENCY - 2);
                    end
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (p_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; q_ready is registered so it stays low during reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            lat_q     <= '0;
            q_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            q_ready_q <= (state_d == ST_IDLE);
        end
    end

    // Response fields captured once at accept, held until the next accept
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_data_q <= 32'd0;
            p_resp_q <= 1'b0;
        end else if (accept) begin
            p_data_q <= exec_data;
            p_resp_q <= exec_resp;
        end
    end

    // Register bank writes happen at the accept edge; entry 0 is never written
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                bank_q[i] <= 32'd0;
            end
        end else if (accept && do_write) begin
            bank_q[idx] <= q_data_i;
        end
    end

`ifdef DMI_RESP_TARGET_STALL_CNT_EN
    // Saturating count of cycles the response is stalled; a clear wins over an increment
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
        end else if (accept && cnt_clr) begin
            stall_cnt_q <= 32'd0;
        end else if ((state_q == ST_RESP) && !p_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

    assign q_ready_o = q_ready_q;
    assign p_valid_o = (state_q == ST_RESP);
    assign p_data_o  = p_data_q;
    assign p_resp_o  = p_resp_q;

    assign regs_o[31:0] = ID_VALUE;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs
        assign regs_o[32*g +: 32] = bank_q[g];
    end

endmodule

// File: tb/tb_dmi_resp_target.sv
// tb/tb_dmi_resp_target.sv - self-checking bench for dmi_resp_target (latency 1 and latency 4 instances)
module tb_dmi_resp_target;

    localparam int          NR  = 16;
    localparam logic [31:0] ID  = 32'h0000_0DB1;
`ifdef DMI_RESP_TARGET_STALL_CNT_EN
    localparam bit          CNT = 1'b1;
`else
    localparam bit          CNT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst     [2];
    logic [6:0]        q_addr  [2];
    logic [1:0]        q_op    [2];
    logic [31:0]       q_data  [2];
    logic              q_valid [2];
    logic              q_ready [2];
    logic [31:0]       p_data  [2];
    logic              p_resp  [2];
    logic              p_valid [2];
    logic              p_ready [2];
    logic [NR*32-1:0]  regs    [2];

    int lat_of [2] = '{1, 4};

    logic [31:0] m_regs  [2][NR];
    logic [31:0] m_stall [2];

    int errors = 0;
    int checks = 0;

    dmi_resp_target #(.ADDR_WIDTH(7), .NUM_REGS(NR), .ID_VALUE(ID), .RESP_LATENCY(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst[0]), .q_addr_i(q_addr[0]), .q_op_i(q_op[0]), .q_data_i(q_data[0]),
        .q_valid_i(q_valid[0]), .q_ready_o(q_ready[0]), .p_data_o(p_data[0]), .p_resp_o(p_resp[0]),
        .p_valid_o(p_valid[0]), .p_ready_i(p_ready[0]), .regs_o(regs[0])
    );

    dmi_resp_target #(.ADDR_WIDTH(7), .NUM_REGS(NR), .ID_VALUE(ID), .RESP_LATENCY(4)) u_lat4 (
        .clk_i(clk), .rst_i(rst[1]), .q_addr_i(q_addr[1]), .q_op_i(q_op[1]), .q_data_i(q_data[1]),
        .q_valid_i(q_valid[1]), .q_ready_o(q_ready[1]), .p_data_o(p_data[1]), .p_resp_o(p_resp[1]),
        .p_valid_o(p_valid[1]), .p_ready_i(p_ready[1]), .regs_o(regs[1])
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkr(input string tag, input logic [NR*32-1:0] obs, input logic [NR*32-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*32-1:0] exp_regs(input int k);
        logic [NR*32-1:0] r;
        for (int i = 0; i < NR; i++) r[32*i +: 32] = (i == 0) ? ID : m_regs[k][i];
        return r;
    endfunction

    task automatic model_clear(input int k);
        for (int i = 0; i < NR; i++) m_regs[k][i] = 32'd0;
        m_stall[k] = 32'd0;
    endtask

    // Behavioural reference: what a request does to the bank and what it answers
    task automatic model_exec(input int k, input logic [1:0] op, input logic [6:0] addr,
                              input logic [31:0] data, output logic [31:0] ed, output logic er);
        ed = 32'd0;
        er = 1'b0;
        if (op == 2'd1) begin
            if (int'(addr) < NR) ed = (addr == 7'd0) ? ID : m_regs[k][addr[3:0]];
            else if (CNT && int'(addr) == NR) ed = m_stall[k];
            else er = 1'b1;
        end else if (op == 2'd2) begin
            if (addr != 7'd0 && int'(addr) < NR) begin
                m_regs[k][addr[3:0]] = data;
                ed = data;
            end else if (CNT && int'(addr) == NR) m_stall[k] = 32'd0;
            else er = 1'b1;
        end else if (op == 2'd3) begin
            er = 1'b1;
        end
    endtask

    task automatic do_reset(input int k);
        rst[k] = 1'b1;
        model_clear(k);
        @(negedge clk);
        chk32("rst_q_ready", 32'(q_ready[k]), 32'd0);
        chk32("rst_p_valid", 32'(p_valid[k]), 32'd0);
        chk32("rst_p_data", p_data[k], 32'd0);
        chk32("rst_p_resp", 32'(p_resp[k]), 32'd0);
        chkr("rst_regs", regs[k], exp_regs(k));
        rst[k] = 1'b0;
        @(negedge clk);
        chk32("rst_ready_after", 32'(q_ready[k]), 32'd1);
    endtask

    // One full request/response; Q is kept busy with a bogus WRITE while the target is not IDLE
    task automatic txn(input int k, input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                       input int stall, output logic [31:0] od, output logic orr);
        logic [31:0] ed;
        logic        er;
        int          n;
        q_op[k] = op; q_addr[k] = addr; q_data[k] = data; q_valid[k] = 1'b1; p_ready[k] = 1'b0;
        n = 0;
        while (!q_ready[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk32("accept_ready", 32'(q_ready[k]), 32'd1);
        model_exec(k, op, addr, data, ed, er);
        @(negedge clk);
        q_op[k] = 2'd2; q_addr[k] = 7'($urandom_range(1, NR - 1)); q_data[k] = $urandom;
        n = 1;
        while (!p_valid[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk32("latency", 32'(n), 32'(lat_of[k]));
        od  = p_data[k];
        orr = p_resp[k];
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk32("stall_valid", 32'(p_valid[k]), 32'd1);
            chk32("stall_data", p_data[k], od);
            chk32("stall_resp", 32'(p_resp[k]), 32'(orr));
            m_stall[k] = m_stall[k] + 32'd1;
        end
        chk32("p_data", od, ed);
        chk32("p_resp", 32'(orr), 32'(er));
        p_ready[k] = 1'b1;
        q_valid[k] = 1'b0;
        @(negedge clk);
        chk32("p_valid_drop", 32'(p_valid[k]), 32'd0);
        chk32("q_ready_back", 32'(q_ready[k]), 32'd1);
        p_ready[k] = 1'b0;
        chkr("regs", regs[k], exp_regs(k));
    endtask

    initial begin
        logic [31:0] d;
        logic        r;
        int          nv;
        logic [6:0]  ra;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; q_addr[k] = '0; q_op[k] = '0; q_data[k] = '0; q_valid[k] = 1'b0; p_ready[k] = 1'b0;
        end
        @(negedge clk);
        do_reset(0);
        do_reset(1);

        txn(0, 2'd1, 7'd0, 32'd0, 0, d, r);
        chk32("id_read", d, 32'h0000_0DB1);
        txn(0, 2'd2, 7'd5, 32'hCAFE_F00D, 0, d, r);
        chk32("wr5_data", d, 32'hCAFE_F00D);
        chk32("reg5_flat", regs[0][191:160], 32'hCAFE_F00D);
        txn(0, 2'd1, 7'd5, 32'd0, 0, d, r);
        chk32("rd5_data", d, 32'hCAFE_F00D);
        txn(0, 2'd2, 7'd0, 32'h1234_5678, 0, d, r);
        chk32("wr0_resp", 32'(r), 32'd1);
        txn(0, 2'd1, 7'd16, 32'd0, 0, d, r);
        chk32("rd16_resp", 32'(r), CNT ? 32'd0 : 32'd1);
        txn(0, 2'd3, 7'd1, 32'hFFFF_FFFF, 0, d, r);
        chk32("op3_resp", 32'(r), 32'd1);
        chk32("op3_data", d, 32'd0);

        txn(1, 2'd2, 7'd7, 32'h0BAD_BEEF, 0, d, r);
        txn(1, 2'd1, 7'd7, 32'd0, 3, d, r);
        chk32("lat4_rd7", d, 32'h0BAD_BEEF);

        // Reset while the latency-4 target is waiting on a write
        q_op[1] = 2'd2; q_addr[1] = 7'd3; q_data[1] = 32'd1; q_valid[1] = 1'b1;
        @(negedge clk);
        q_valid[1] = 1'b0;
        rst[1] = 1'b1;
        model_clear(1);
        @(negedge clk);
        rst[1] = 1'b0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (p_valid[1]) nv++;
        end
        chk32("rst_no_resp", 32'(nv), 32'd0);
        chk32("rst_reg3", regs[1][127:96], 32'd0);
        txn(1, 2'd1, 7'd3, 32'd0, 0, d, r);
        chk32("rst_rd3", d, 32'd0);

        txn(0, 2'd1, 7'd1, 32'd0, 5, d, r);
        txn(0, 2'd1, 7'd16, 32'd0, 0, d, r);
        chk32("stall_cnt5", d, CNT ? 32'd5 : 32'd0);
        txn(0, 2'd2, 7'd16, 32'hDEAD_0001, 0, d, r);
        txn(0, 2'd1, 7'd16, 32'd0, 0, d, r);
        chk32("stall_cnt_clr", d, 32'd0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    ra = 7'($urandom_range(0, NR - 1));
                2:       ra = 7'($urandom_range(NR, NR + 1));
                default: ra = 7'($urandom_range(0, 127));
            endcase
            txn(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom,
                int'($urandom_range(0, 3)), d, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
